// File: rtl/ili_fill_rect_pkg.sv
// Shared constants and types for the ILI9341 rectangle-fill sequencer.
package pkg_ili9341;

    localparam logic [7:0] ILI_CASET = 8'h2A;
    localparam logic [7:0] ILI_PASET = 8'h2B;
    localparam logic [7:0] ILI_RAMWR = 8'h2C;

    // Steps 0..10 are the fixed header; 11/12 repeat once per pixel.
    localparam logic [3:0] STEP_PIX_HI = 4'd11;
    localparam logic [3:0] STEP_PIX_LO = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_LOAD,
        S_WAIT,
        S_NEXT,
        S_RELEASE
    } e_fill_state;

    typedef struct packed {
        logic [8:0]  x0;
        logic [8:0]  x1;
        logic [8:0]  y0;
        logic [8:0]  y1;
        logic [15:0] color;
    } st_fill_req;

endpackage

// File: rtl/ili_fill_rect_fill_hdr_rom.sv
// Maps a step index and the latched request to the {dc, byte} to transmit.
module fill_hdr_rom
    import pkg_ili9341::*;
(
    input  logic [3:0] step,
    input  st_fill_req req,
    output logic       dc,
    output logic [7:0] data
);

    always_comb begin
        dc   = 1'b1;
        data = '0;
        case (step)
            4'd0:        begin dc = 1'b0; data = ILI_CASET; end
            4'd1:        data = {7'b0, req.x0[8]};
            4'd2:        data = req.x0[7:0];
            4'd3:        data = {7'b0, req.x1[8]};
            4'd4:        data = req.x1[7:0];
            4'd5:        begin dc = 1'b0; data = ILI_PASET; end
            4'd6:        data = {7'b0, req.y0[8]};
            4'd7:        data = req.y0[7:0];
            4'd8:        data = {7'b0, req.y1[8]};
            4'd9:        data = req.y1[7:0];
            4'd10:       begin dc = 1'b0; data = ILI_RAMWR; end
            STEP_PIX_HI: data = req.color[15:8];
            STEP_PIX_LO: data = req.color[7:0];
            default:     ;
        endcase
    end

endmodule

// File: rtl/ili_fill_rect.sv
// Fills a panel rectangle with one colour: CASET/PASET/RAMWR header, then N pixels,
// one byte per send/done handshake with the SPI engine.
module ili_fill_rect
    import pkg_ili9341::*;
#(
    parameter int unsigned WIDTH    = 240,
    parameter int unsigned HEIGHT   = 320,
    parameter int unsigned CS_SETUP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [8:0]  i_x0,
    input  logic [8:0]  i_x1,
    input  logic [8:0]  i_y0,
    input  logic [8:0]  i_y1,
    input  logic [15:0] i_color,
    input  logic        i_byte_done,
    output logic        o_send,
    output logic [7:0]  o_data,
    output logic        o_dc,
    output logic        o_cs,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned SW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
    localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP - 1);
    localparam logic [8:0] X_LIM = 9'(WIDTH);
    localparam logic [8:0] Y_LIM = 9'(HEIGHT);

    e_fill_state   state, state_n;
    st_fill_req    req;
    logic [3:0]    step, step_n;
    logic [16:0]   pix_cnt, pix_cnt_n;
    logic [SW-1:0] setup_cnt, setup_cnt_n;
    logic          reject;
    logic [8:0]    span_x, span_y;
    logic [16:0]   area;
    logic          rom_dc;
    logic [7:0]    rom_data;

    always_comb begin
        reject = (req.x0 > req.x1) || (req.y0 > req.y1) ||
                 (req.x1 >= X_LIM) || (req.y1 >= Y_LIM);
        span_x = req.x1 - req.x0 + 9'd1;
        span_y = req.y1 - req.y0 + 9'd1;
        area   = 17'(span_x) * 17'(span_y);
    end

    // Looks up the next step so the byte is registered on the edge entering LOAD.
    fill_hdr_rom u_rom (
        .step (step_n),
        .req  (req),
        .dc   (rom_dc),
        .data (rom_data)
    );

    always_comb begin
        state_n     = state;
        step_n      = step;
        pix_cnt_n   = pix_cnt;
        setup_cnt_n = setup_cnt;
        case (state)
            S_IDLE: begin
                if (i_start) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (reject) begin
                    state_n = S_IDLE;
                end else begin
                    state_n     = S_SETUP;
                    step_n      = '0;
                    pix_cnt_n   = area;
                    setup_cnt_n = '0;
                end
            end
            S_SETUP: begin
                if (setup_cnt == SETUP_LAST) state_n = S_LOAD;
                else setup_cnt_n = setup_cnt + SW'(1);
            end
            S_LOAD: state_n = S_WAIT;
            S_WAIT: begin
                if (i_byte_done) state_n = S_NEXT;
            end
            S_NEXT: begin
                if (step == STEP_PIX_LO) begin
                    pix_cnt_n = pix_cnt - 17'd1;
                    if (pix_cnt == 17'd1) begin
                        state_n = S_RELEASE;
                    end else begin
                        step_n  = STEP_PIX_HI;
                        state_n = S_LOAD;
                    end
                end else begin
                    step_n  = step + 4'd1;
                    state_n = S_LOAD;
                end
            end
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req       <= '0;
            step      <= '0;
            pix_cnt   <= '0;
            setup_cnt <= '0;
            o_send    <= 1'b0;
            o_data    <= '0;
            o_dc      <= 1'b0;
            o_cs      <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            pix_cnt   <= pix_cnt_n;
            setup_cnt <= setup_cnt_n;
            if (state == S_IDLE && i_start) begin
                req <= '{x0: i_x0, x1: i_x1, y0: i_y0, y1: i_y1, color: i_color};
            end
            o_send <= (state_n == S_LOAD);
            if (state_n == S_LOAD) begin
                o_data <= rom_data;
                o_dc   <= rom_dc;
            end
            o_busy <= (state_n inside {S_CHECK, S_SETUP, S_LOAD, S_WAIT, S_NEXT});
            o_done <= (state_n == S_RELEASE);
            o_err  <= (state == S_CHECK) && reject;
            if (state == S_CHECK && !reject) o_cs <= 1'b0;
            else if (state_n == S_RELEASE) o_cs <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ili_fill_rect.sv
// Scoreboard bench for ili_fill_rect: stimulus pushes expected bytes/events, a monitor checks them.
module tb_ili_fill_rect;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [8:0]  i_x0, i_x1, i_y0, i_y1;
    logic [15:0] i_color;
    logic        i_byte_done;
    logic        eng_done, spur_done;
    logic        o_send, o_dc, o_cs, o_busy, o_done, o_err;
    logic [7:0]  o_data;

    always #5 clk = ~clk;
    assign i_byte_done = eng_done | spur_done;

    ili_fill_rect #(.WIDTH(240), .HEIGHT(320), .CS_SETUP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_x0        (i_x0),
        .i_x1        (i_x1),
        .i_y0        (i_y0),
        .i_y1        (i_y1),
        .i_color     (i_color),
        .i_byte_done (i_byte_done),
        .o_send      (o_send),
        .o_data      (o_data),
        .o_dc        (o_dc),
        .o_cs        (o_cs),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [8:0] exp_q[$];   // {dc, byte}
    int         ev_q[$];    // 1 = done, 2 = err
    chk_t       chk_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    bit         fast_eng = 1'b0;

    task automatic chk_push(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: the only process that steps the counters.
    initial begin : monitor
        chk_t       c;
        logic [8:0] e;
        int         ev, exp_ev;
        forever begin
            @(negedge clk);
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                n_vec++;
                if (c.act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
                end
            end
            if (o_send === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_send: got dc %b byte %h, expected no byte", o_dc, o_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_cs, o_dc, o_data} !== {1'b0, e}) begin
                        n_bad++;
                        $display("FAIL byte: got cs %b dc %b %h expected cs 0 dc %b %h",
                                 o_cs, o_dc, o_data, e[8], e[7:0]);
                    end
                end
            end
            if (o_done === 1'b1 || o_err === 1'b1) begin
                ev = (o_done === 1'b1) ? 1 : 2;
                n_vec++;
                if (ev_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %0d expected none", ev);
                end else begin
                    exp_ev = ev_q.pop_front();
                    if (ev != exp_ev) begin
                        n_bad++;
                        $display("FAIL event_kind: got %0d expected %0d", ev, exp_ev);
                    end
                end
                n_vec++;
                if ({o_cs, o_busy} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL end_state cs/busy: got %b expected 10", {o_cs, o_busy});
                end
            end
        end
    end

    // SPI engine model: byte completes 1..40 cycles after o_send (1 in fast mode).
    initial begin : engine
        int d;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_send === 1'b1) begin
                d = fast_eng ? 1 : int'($urandom_range(1, 40));
                repeat (d) @(negedge clk);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    task automatic push_rect(input logic [8:0] x0, x1, y0, y1, input logic [15:0] c,
                             input int max_pix);
        int n;
        n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
        if (max_pix > 0 && max_pix < n) n = max_pix;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 7'b0, x0[8]});
        exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({1'b1, 7'b0, x1[8]});
        exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 7'b0, y0[8]});
        exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({1'b1, 7'b0, y1[8]});
        exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    task automatic run_req(input logic [8:0] x0, x1, y0, y1, input logic [15:0] c);
        @(negedge clk);
        i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1; i_color = c;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (ev_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_push({tag, "_completion"}, 32'(ev_q.size()), 32'd0);
        chk_push({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        if (ev_q.size() != 0) begin
            ev_q.delete();
            exp_q.delete();
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [8:0] t1 [15] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
                                9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
                                9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
        logic [8:0] rj [4][4] = '{'{9'd5, 9'd3,   9'd0, 9'd0},
                                  '{9'd0, 9'd240, 9'd0, 9'd0},
                                  '{9'd0, 9'd0,   9'd0, 9'd320},
                                  '{9'd0, 9'd0,   9'd7, 9'd6}};
        bit cs_fell;
        int pulses, k;

        rst = 1'b1; i_start = 1'b0; spur_done = 1'b0;
        i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0; i_color = '0;
        repeat (3) @(negedge clk);
        chk_push("reset_outputs", 32'({o_send, o_data, o_dc, o_cs, o_busy, o_done, o_err}), 32'h8);
        rst = 1'b0;
        @(negedge clk);
        chk_push("idle_outputs", 32'({o_send, o_data, o_dc, o_cs, o_busy, o_done, o_err}), 32'h8);

        // (0,0)-(1,0) red, hand-written byte stream.
        foreach (t1[i]) exp_q.push_back(t1[i]);
        ev_q.push_back(1);
        run_req(9'd0, 9'd1, 9'd0, 9'd0, 16'hF800);
        wait_done(20000, "rect2x1");

        // Spurious i_byte_done in IDLE, then across SETUP and LOAD.
        push_rect(9'd3, 9'd12, 9'd5, 9'd9, 16'h07E0, 0);
        ev_q.push_back(1);
        @(negedge clk);
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        i_x0 = 9'd3; i_x1 = 9'd12; i_y0 = 9'd5; i_y1 = 9'd9; i_color = 16'h07E0;
        i_start = 1'b1; spur_done = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        spur_done = 1'b1;
        repeat (2) @(negedge clk);
        spur_done = 1'b0;
        wait_done(20000, "spurious_done");

        // Rejected requests: err pulse only, cs never falls.
        for (int r = 0; r < 4; r++) begin
            ev_q.push_back(2);
            cs_fell = 1'b0;
            run_req(rj[r][0], rj[r][1], rj[r][2], rj[r][3], 16'hFFFF);
            repeat (6) begin
                @(negedge clk);
                if (o_cs !== 1'b1) cs_fell = 1'b1;
            end
            chk_push("reject_cs_high", 32'(cs_fell), 32'd0);
            wait_done(100, "reject");
        end

        // i_start noise with random coordinates during a busy fill.
        push_rect(9'd100, 9'd109, 9'd200, 9'd204, 16'h1234, 0);
        ev_q.push_back(1);
        run_req(9'd100, 9'd109, 9'd200, 9'd204, 16'h1234);
        pulses = 0;
        while (pulses < 100 && o_busy === 1'b1) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            if (o_busy === 1'b1) begin
                i_x0 = 9'($urandom_range(0, 239)); i_x1 = 9'($urandom_range(0, 239));
                i_y0 = 9'($urandom_range(0, 319)); i_y1 = 9'($urandom_range(0, 319));
                i_color = 16'($urandom);
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
                pulses++;
            end
        end
        wait_done(20000, "start_noise");

        // Full-width row: 240 pixels, exercises 9-bit column high byte = 0 with x1=239.
        fast_eng = 1'b1;
        push_rect(9'd0, 9'd239, 9'd7, 9'd7, 16'hA5C3, 0);
        ev_q.push_back(1);
        run_req(9'd0, 9'd239, 9'd7, 9'd7, 16'hA5C3);
        wait_done(10000, "row240");

        // Full screen: header and first 150 pixels, then reset mid-stream.
        push_rect(9'd0, 9'd239, 9'd0, 9'd319, 16'h001F, 150);
        ev_q.push_back(1);
        run_req(9'd0, 9'd239, 9'd0, 9'd319, 16'h001F);
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk_push("fullscreen_stream_left", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        ev_q.delete();
        @(negedge clk);
        chk_push("reset_mid_stream cs/busy/send", 32'({o_cs, o_busy, o_send}), 32'h4);
        rst = 1'b0;
        fast_eng = 1'b0;
        repeat (5) @(negedge clk);

        // Single pixel after the reset.
        push_rect(9'd10, 9'd10, 9'd20, 9'd20, 16'hBEEF, 0);
        ev_q.push_back(1);
        run_req(9'd10, 9'd10, 9'd20, 9'd20, 16'hBEEF);
        wait_done(5000, "n1_after_reset");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
